uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with 2-FF synchroniser, error flags and valid/ready output
module uart_rx_param #(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk50M,
  input  logic                 rst,
  input  logic                 rxd_pin,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_MODE  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                 sync1;
  logic                 rx_s;
  logic                 rx_d;
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 at_centre;

  assign at_centre = (cnt == CNT_LAST);

  // Synchroniser flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rxd_pin;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      // Acceptance; a delivery in the same cycle overrides it below.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          if (rx_d && !rx_s) begin
            state   <= S_START;
            rx_busy <= 1'b1;
            perr    <= 1'b0;
            ferr    <= 1'b0;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (at_centre) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 4'd1;
            if (bit_idx == DATA_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (at_centre) begin
            cnt   <= '0;
            perr  <= (^{shreg, rx_s}) ^ ODD_MODE;
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (at_centre) begin
            cnt      <= '0;
            ferr     <= ferr | ~rx_s;
            stop_idx <= stop_idx + 1'b1;
            // Deliver straight from the last centre; the trailing half stop bit is spent in IDLE.
            if (stop_idx == STOP_LAST) begin
              rx_data    <= shreg;
              frame_err  <= ferr | ~rx_s;
              parity_err <= perr;
              overrun    <= rx_valid & ~rx_ready;
              rx_valid   <= 1'b1;
              rx_busy    <= 1'b0;
              state      <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 8E1 instances at 115200 baud)
module tb_uart_rx_param;

  localparam int BIT  = 50000000 / 115200;
  localparam int HALF = BIT / 2;
  localparam int IDLE_GAP = 250;

  logic clk50M = 1'b0;
  always #5 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc <= cyc + 1;

  logic       rst;
  logic       rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_fe, a_pe, a_ov, a_busy;
  logic       b_valid, b_fe, b_pe, b_ov, b_busy;

  uart_rx_param #(.CLK_HZ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk50M(clk50M), .rst(rst), .rxd_pin(rxd_a), .rx_ready(rdy_a),
    .rx_data(a_data), .rx_valid(a_valid), .frame_err(a_fe), .parity_err(a_pe),
    .overrun(a_ov), .rx_busy(a_busy)
  );

  uart_rx_param #(.CLK_HZ(50000000), .BAUD(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk50M(clk50M), .rst(rst), .rxd_pin(rxd_b), .rx_ready(rdy_b),
    .rx_data(b_data), .rx_valid(b_valid), .frame_err(b_fe), .parity_err(b_pe),
    .overrun(b_ov), .rx_busy(b_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Delivery monitors: count rising edges of rx_valid and snapshot the word.
  int         a_cnt = 0, a_w = 0, a_cyc = 0, b_cnt = 0;
  logic [7:0] a_ld = 8'h00, b_ld = 8'h00;
  logic       a_lfe = 1'b0, a_lpe = 1'b0, a_lov = 1'b0, b_lfe = 1'b0, b_lpe = 1'b0;
  logic       a_prev = 1'b0, b_prev = 1'b0;

  always @(negedge clk50M) begin
    if (a_valid) begin
      if (!a_prev) begin
        a_cnt <= a_cnt + 1;
        a_ld  <= a_data;
        a_lfe <= a_fe;
        a_lpe <= a_pe;
        a_lov <= a_ov;
        a_cyc <= cyc;
        a_w   <= 1;
      end else begin
        a_w <= a_w + 1;
      end
    end
    a_prev <= a_valid;
    if (b_valid && !b_prev) begin
      b_cnt <= b_cnt + 1;
      b_ld  <= b_data;
      b_lfe <= b_fe;
      b_lpe <= b_pe;
    end
    b_prev <= b_valid;
  end

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       sb;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #1;
    end
  endtask

  task automatic hold(input int which, input logic v, input int n);
    if (which == 0) rxd_a = v;
    else rxd_b = v;
    step(n);
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic pb, input logic sb);
    hold(which, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(which, d[i], BIT);
    if (which == 1) hold(which, pb, BIT);
    hold(which, sb, BIT);
  endtask

  // Reference rule for even parity: data ones plus parity bit must be even.
  function automatic logic even_parity_error(input logic [7:0] d, input logic pb);
    int ones = int'(pb);
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) != 0;
  endfunction

  task automatic run_b(input string name, input logic [7:0] d, input logic pb, input logic sb,
                       input logic [7:0] exp_d, input logic exp_pe, input logic exp_fe);
    int c0;
    hold(1, 1'b1, 10);
    c0 = b_cnt;
    send(1, d, pb, sb);
    hold(1, 1'b1, IDLE_GAP);
    check({name, "_count"}, b_cnt - c0, 1);
    check({name, "_data"}, b_ld, exp_d);
    check({name, "_perr"}, b_lpe, exp_pe);
    check({name, "_ferr"}, b_lfe, exp_fe);
  endtask

  initial begin
    int t0, c0, lat, exp_lat;
    logic [7:0] rd;
    logic rp, rs;

    vt[0] = '{d: 8'h37, pb: 1'b1, sb: 1'b1, exp_d: 8'h37, exp_pe: 1'b0, exp_fe: 1'b0};
    vt[1] = '{d: 8'h37, pb: 1'b0, sb: 1'b1, exp_d: 8'h37, exp_pe: 1'b1, exp_fe: 1'b0};
    vt[2] = '{d: 8'hFF, pb: 1'b1, sb: 1'b1, exp_d: 8'hFF, exp_pe: 1'b1, exp_fe: 1'b0};
    vt[3] = '{d: 8'h80, pb: 1'b1, sb: 1'b0, exp_d: 8'h80, exp_pe: 1'b0, exp_fe: 1'b1};

    rst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    step(3);
    check("reset_a_data", a_data, 0);
    check("reset_a_valid", a_valid, 0);
    check("reset_a_flags", {a_fe, a_pe, a_ov}, 0);
    check("reset_a_busy", a_busy, 0);
    check("reset_b_valid", b_valid, 0);
    rst = 1'b0;
    step(5);

    // 8N1 frame 0xA5 with latency and pulse-width checks
    c0 = a_cnt;
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b1);
    hold(0, 1'b1, IDLE_GAP);
    exp_lat = 3 + HALF + 9 * BIT + 1;
    lat = a_cyc - t0;
    check("a5_count", a_cnt - c0, 1);
    check("a5_data", a_ld, 8'hA5);
    check("a5_flags", {a_lfe, a_lpe, a_lov}, 0);
    check("a5_valid_width", a_w, 1);
    check("a5_latency_in_window", (lat >= exp_lat - 2) && (lat <= exp_lat + 2), 1);

    // Even-parity table on dut_b
    for (int i = 0; i < 4; i++)
      run_b($sformatf("vec%0d", i), vt[i].d, vt[i].pb, vt[i].sb, vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe);

    // Start glitch: 100 low cycles are rejected at the half-bit sample
    c0 = a_cnt;
    hold(0, 1'b0, 50);
    check("glitch_busy_early", a_busy, 1);
    hold(0, 1'b0, 50);
    hold(0, 1'b1, HALF - 102);
    check("glitch_busy_before_half", a_busy, 1);
    hold(0, 1'b1, 10);
    check("glitch_busy_after_half", a_busy, 0);
    hold(0, 1'b1, BIT);
    check("glitch_no_word", a_cnt - c0, 0);

    // Break: stop bit low, line held low for 20 bit times
    c0 = a_cnt;
    send(0, 8'h5A, 1'b0, 1'b0);
    hold(0, 1'b0, 20 * BIT);
    hold(0, 1'b1, IDLE_GAP);
    check("break_count", a_cnt - c0, 1);
    check("break_data", a_ld, 8'h5A);
    check("break_ferr", a_lfe, 1);
    c0 = a_cnt;
    send(0, 8'h01, 1'b0, 1'b1);
    hold(0, 1'b1, IDLE_GAP);
    check("after_break_count", a_cnt - c0, 1);
    check("after_break_data", a_ld, 8'h01);
    check("after_break_flags", {a_lfe, a_lpe, a_lov}, 0);

    // Back-to-back frames with the consumer stalled
    rdy_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1);
    check("b2b_first_data", a_data, 8'h11);
    check("b2b_first_overrun", a_ov, 0);
    send(0, 8'h22, 1'b0, 1'b1);
    hold(0, 1'b1, 10);
    check("b2b_valid", a_valid, 1);
    check("b2b_data", a_data, 8'h22);
    check("b2b_overrun", a_ov, 1);

    // Reset at data bit 4 with a word still pending
    fork
      send(0, 8'h99, 1'b0, 1'b1);
      begin
        step(5 * BIT + HALF);
        rst = 1'b1;
        #1;
        check("midrst_valid", a_valid, 0);
        check("midrst_data", a_data, 0);
        check("midrst_flags", {a_fe, a_pe, a_ov}, 0);
        check("midrst_busy", a_busy, 0);
      end
    join
    rst = 1'b0;
    hold(0, 1'b1, 10);

    c0 = a_cnt;
    send(0, 8'hC3, 1'b0, 1'b1);
    hold(0, 1'b1, 10);
    check("c3_count", a_cnt - c0, 1);
    check("c3_data", a_data, 8'hC3);
    check("c3_flags", {a_fe, a_pe, a_ov}, 0);
    rdy_a = 1'b1;
    step(1);
    check("accept_clears_valid", a_valid, 0);

    // Randomised frames on dut_b against the parity/stop rules
    for (int i = 0; i < 3; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      run_b($sformatf("rand%0d", i), rd, rp, rs, rd, even_parity_error(rd, rp), ~rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
